// File: rtl/avalon_pkg.sv
// avalon_pkg: shared types and defaults for the Avalon-MM initiator.
// FSM states, response codes and default limits.
package avalon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    ERR
  } state_t;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_RSVD   = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  localparam int MAX_BURST_DEF = 784;
  localparam int TIMEOUT_DEF   = 1023;

endpackage

// File: rtl/avalon_mm_master_if.sv
// avalon_mm_master_if: Avalon-MM bus between initiator and slave.
// Bus signals only; clock and reset stay plain ports.
interface avalon_mm_master_if
  import avalon_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BCNT_W = 10
) ();

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              beginbursttransfer;
  logic [BCNT_W-1:0] burstcount;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  resp_t             response;
  logic              writeresponsevalid;

  modport master (
    output address, read, write,
    output beginbursttransfer, burstcount,
    output writedata,
    input  waitrequest, readdata,
    input  readdatavalid, response,
    input  writeresponsevalid
  );

  modport slave (
    input  address, read, write,
    input  beginbursttransfer, burstcount,
    input  writedata,
    output waitrequest, readdata,
    output readdatavalid, response,
    output writeresponsevalid
  );

endinterface

// File: rtl/avalon_beat_counter.sv
// avalon_beat_counter: remaining-beat counter for one command.
// Loaded on accept, decremented per beat, flags the final beat.
module avalon_beat_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic         beat,
  input  logic [W-1:0] len,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len;
    end else if (beat && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == W'(1));

endmodule

// File: rtl/avalon_mm_master.sv
// avalon_mm_master: Avalon-MM initiator turning local commands
// into single and burst read/write transactions.
module avalon_mm_master
  import avalon_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int BCNT_W    = 10,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BCNT_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output resp_t             status,
  output logic              timeout_err,
  avalon_mm_master_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state, state_nx;
  logic          accept, len_ok, active;
  logic          progress, expire;
  logic          wr_beat, rd_beat, last;
  logic [TW-1:0] tcnt;

  assign len_ok = (cmd_len != '0) &&
                  (int'(cmd_len) <= MAX_BURST);
  assign active = state inside
                  {WR_DATA, WR_RESP, RD_REQ, RD_DATA};
  assign wr_ready = bus.write && !bus.waitrequest;

  avalon_beat_counter #(.W(BCNT_W)) u_cnt (
    .clk  (clk),
    .n_rst(n_rst),
    .load (accept),
    .beat (wr_beat | rd_beat),
    .len  (cmd_len),
    .last (last)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    cmd_ready     = 1'b0;
    accept        = 1'b0;
    wr_beat       = 1'b0;
    rd_beat       = 1'b0;
    progress      = 1'b0;
    bus.write     = 1'b0;
    bus.writedata = '0;
    unique case (state)
      IDLE: begin
        // done is a pulse in IDLE; hold off the next command one cycle
        cmd_ready = !done;
        accept    = cmd_valid && !done;
        if (accept) begin
          if (!len_ok)        state_nx = ERR;
          else if (cmd_write) state_nx = WR_DATA;
          else                state_nx = RD_REQ;
        end
      end
      WR_DATA: begin
        bus.write     = wr_valid;
        bus.writedata = wr_data;
        wr_beat       = wr_valid && !bus.waitrequest;
        progress      = wr_beat;
        if (wr_beat && last) state_nx = WR_RESP;
      end
      WR_RESP: begin
        progress = bus.writeresponsevalid;
        if (progress) state_nx = IDLE;
      end
      RD_REQ: begin
        progress = bus.read && !bus.waitrequest;
        if (progress) state_nx = RD_DATA;
      end
      RD_DATA: begin
        rd_beat  = bus.readdatavalid;
        progress = rd_beat;
        if (rd_beat && last) state_nx = IDLE;
      end
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    expire = active && !progress &&
             (tcnt == TW'(TIMEOUT - 1));
    if (expire) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      bus.address            <= '0;
      bus.burstcount         <= '0;
      bus.beginbursttransfer <= 1'b0;
      bus.read               <= 1'b0;
      rd_data                <= '0;
      rd_valid               <= 1'b0;
      done                   <= 1'b0;
      status                 <= RESP_OKAY;
      timeout_err            <= 1'b0;
      tcnt                   <= '0;
    end else begin
      bus.beginbursttransfer <= 1'b0;
      rd_valid               <= rd_beat;
      done                   <= 1'b0;
      timeout_err            <= 1'b0;
      if (accept) begin
        status <= RESP_OKAY;
        if (len_ok) begin
          bus.address            <= cmd_addr;
          bus.burstcount         <= cmd_len;
          bus.beginbursttransfer <= cmd_len > BCNT_W'(1);
          bus.read               <= !cmd_write;
        end
      end
      if (accept || progress) tcnt <= '0;
      else if (active)        tcnt <= tcnt + 1'b1;
      if (rd_beat) rd_data <= bus.readdata;
      if (state == RD_REQ && progress) bus.read <= 1'b0;
      // only the first non-OKAY response sticks
      if ((rd_beat || (state == WR_RESP && progress)) &&
          status == RESP_OKAY)
        status <= bus.response;
      if ((rd_beat && last) ||
          (state == WR_RESP && progress))
        done <= 1'b1;
      if (state == ERR) begin
        done   <= 1'b1;
        status <= RESP_DECERR;
      end
      if (expire) begin
        done        <= 1'b1;
        timeout_err <= 1'b1;
        bus.read    <= 1'b0;
      end
    end
  end

endmodule
